// File: rtl/history_extract_pkg.sv
// history_pkg: shared constants, header slot layout, FSM state type and the
// per-beat tuple unpacking helper for the history_extract block.
package history_pkg;

    localparam int unsigned TUPLE_WIDTH     = 112;
    localparam int unsigned NUM_HISTORY     = 16;
    localparam int unsigned HDR_BEATS       = 4;
    localparam int unsigned TUPLES_PER_BEAT = 4;
    localparam int unsigned SHADOW_TUPLES   = 12;
    localparam int unsigned IDX_WIDTH       = 4;
    localparam int unsigned HDR_DATA_WIDTH  = 512;

    // Tuple slot LSBs inside every header beat; slot 0 is the most significant.
    localparam int unsigned T0_LSB  = 400;
    localparam int unsigned T1_LSB  = 288;
    localparam int unsigned T2_LSB  = 176;
    localparam int unsigned T3_LSB  = 64;
    localparam int unsigned PTR_MSB = 63;
    localparam int unsigned PTR_LSB = 60;

    typedef logic [TUPLE_WIDTH-1:0]             tuple_t;
    typedef tuple_t [TUPLES_PER_BEAT-1:0]       beat_tuples_t;

    typedef enum logic [2:0] {
        HDR0    = 3'd0,
        HDR1    = 3'd1,
        HDR2    = 3'd2,
        HDR3    = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    // Element j of the result is the j-th tuple carried by the beat.
    function automatic beat_tuples_t unpack_tuples(input logic [HDR_DATA_WIDTH-1:0] d);
        beat_tuples_t t;
        t[0] = d[T0_LSB +: TUPLE_WIDTH];
        t[1] = d[T1_LSB +: TUPLE_WIDTH];
        t[2] = d[T2_LSB +: TUPLE_WIDTH];
        t[3] = d[T3_LSB +: TUPLE_WIDTH];
        return t;
    endfunction

endpackage

// File: rtl/history_extract_if.sv
// AXI-Stream bundle used for both the slave and master sides of history_extract.
interface history_extract_if #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/history_extract_bank.sv
// history_bank: shadow registers for header beats 0..2, committed 16-entry
// tuple bank with pointer, and a registered read port.
module history_bank
    import history_pkg::*;
(
    input  logic                 axis_aclk,
    input  logic                 axis_reset,
    input  logic                 i_wr_en,
    input  logic [1:0]           i_wr_beat,
    input  beat_tuples_t         i_tuples,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    input  logic                 i_commit,
    input  logic [IDX_WIDTH-1:0] i_rd_idx,
    output tuple_t               o_rd_tuple,
    output logic [IDX_WIDTH-1:0] o_ptr
);

    tuple_t               r_shadow [SHADOW_TUPLES];
    logic [IDX_WIDTH-1:0] r_shadow_ptr;
    tuple_t               r_bank   [NUM_HISTORY];
    logic [IDX_WIDTH-1:0] r_ptr;
    tuple_t               r_rd_tuple;

    // Stage header beats 0..2; pointer only lives in beat 0.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            for (int i = 0; i < int'(SHADOW_TUPLES); i++) r_shadow[i] <= '0;
            r_shadow_ptr <= '0;
        end else if (i_wr_en) begin
            for (int j = 0; j < int'(TUPLES_PER_BEAT); j++) begin
                r_shadow[{i_wr_beat, j[1:0]}] <= i_tuples[j];
            end
            if (i_wr_beat == 2'd0) r_shadow_ptr <= i_ptr;
        end
    end

    // Commit shadow + the live beat-3 tuples + pointer in a single edge.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            for (int i = 0; i < int'(NUM_HISTORY); i++) r_bank[i] <= '0;
            r_ptr <= '0;
        end else if (i_commit) begin
            for (int i = 0; i < int'(SHADOW_TUPLES); i++) r_bank[i] <= r_shadow[i];
            for (int j = 0; j < int'(TUPLES_PER_BEAT); j++) begin
                r_bank[int'(SHADOW_TUPLES) + j] <= i_tuples[j];
            end
            r_ptr <= r_shadow_ptr;
        end
    end

    // Registered read; a read in the commit cycle sees pre-commit contents.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) r_rd_tuple <= '0;
        else            r_rd_tuple <= r_bank[i_rd_idx];
    end

    assign o_rd_tuple = r_rd_tuple;
    assign o_ptr      = r_ptr;

endmodule

// File: rtl/history_extract.sv
// history_extract: strips the 4 prepended history beats, commits their tuples
// and pointer to history_bank, and forwards the payload through one output
// register. Optional build macro HISTORY_EXTRACT_CHECK_EN adds header format
// checking (reserved bits and tkeep).
module history_extract
    import history_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                   axis_aclk,
    input  logic                   axis_reset,
    history_extract_if.slave       s_axis,
    history_extract_if.master      m_axis,
    input  logic [IDX_WIDTH-1:0]   hist_rd_idx,
    output logic [TUPLE_WIDTH-1:0] hist_rd_tuple,
    output logic [IDX_WIDTH-1:0]   hist_ptr,
    output logic                   hist_update,
    output logic [CNT_WIDTH-1:0]   hist_seq,
    output logic [CNT_WIDTH-1:0]   pkt_cnt,
    output logic [CNT_WIDTH-1:0]   hdr_err_cnt
);

    if (C_M_AXIS_DATA_WIDTH != HDR_DATA_WIDTH || C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH ||
        C_S_AXIS_TUSER_WIDTH != C_M_AXIS_TUSER_WIDTH) begin : g_bad_cfg
        $error("history_extract: unsupported AXIS width configuration");
    end

    state_t                        r_state, w_state_nxt;
    logic                          w_s_ready, w_s_hs, w_hdr_hs, w_ld, w_m_hs;
    logic                          w_commit, w_err_inc, w_hdr_bad;
    beat_tuples_t                  w_tuples;
    logic                          r_m_valid, r_m_tlast;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   r_m_tdata;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] r_m_tkeep;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  r_m_tuser;
    logic                          r_hist_update;
    logic [CNT_WIDTH-1:0]          r_hist_seq, r_pkt_cnt, r_hdr_err_cnt;

    assign w_tuples = unpack_tuples(s_axis.tdata);
    assign w_s_hs   = s_axis.tvalid && w_s_ready;
    assign w_hdr_hs = w_s_hs && (r_state != PAYLOAD);
    assign w_ld     = w_s_hs && (r_state == PAYLOAD);
    assign w_m_hs   = r_m_valid && m_axis.tready;

`ifdef HISTORY_EXTRACT_CHECK_EN
    logic r_bad;
    logic w_beat_bad;

    // Beat 0 carries the pointer in [63:60]; only [59:0] are reserved there.
    always_comb begin
        w_beat_bad = (s_axis.tkeep != '1);
        if (r_state == HDR0) w_beat_bad = w_beat_bad || (|s_axis.tdata[PTR_LSB-1:0]);
        else                 w_beat_bad = w_beat_bad || (|s_axis.tdata[PTR_MSB:0]);
    end

    // Sticky per-header error flag, cleared once the header ends.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset)                                    r_bad <= 1'b0;
        else if (w_hdr_hs && (s_axis.tlast || r_state == HDR3)) r_bad <= 1'b0;
        else if (w_hdr_hs)                                 r_bad <= r_bad || w_beat_bad;
    end

    assign w_hdr_bad = r_bad || w_beat_bad;
`else
    assign w_hdr_bad = 1'b0;
`endif

    assign w_commit  = w_hdr_hs && (r_state == HDR3) && !s_axis.tlast && !w_hdr_bad;
    // One count per header, even if it is both malformed and cut short.
    assign w_err_inc = w_hdr_hs && (s_axis.tlast || ((r_state == HDR3) && w_hdr_bad));

    // Next state and slave ready.
    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b1;
        unique case (r_state)
            HDR0:    if (s_axis.tvalid) w_state_nxt = s_axis.tlast ? HDR0 : HDR1;
            HDR1:    if (s_axis.tvalid) w_state_nxt = s_axis.tlast ? HDR0 : HDR2;
            HDR2:    if (s_axis.tvalid) w_state_nxt = s_axis.tlast ? HDR0 : HDR3;
            HDR3:    if (s_axis.tvalid) w_state_nxt = s_axis.tlast ? HDR0 : PAYLOAD;
            PAYLOAD: begin
                w_s_ready = !r_m_valid || m_axis.tready;
                if (s_axis.tvalid && w_s_ready && s_axis.tlast) w_state_nxt = HDR0;
            end
            default: w_state_nxt = HDR0;
        endcase
    end

    // State register.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) r_state <= HDR0;
        else            r_state <= w_state_nxt;
    end

    // Payload output register; may still drain while the next header arrives.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_m_valid <= 1'b0;
            r_m_tdata <= '0;
            r_m_tkeep <= '0;
            r_m_tuser <= '0;
            r_m_tlast <= 1'b0;
        end else if (w_ld) begin
            r_m_valid <= 1'b1;
            r_m_tdata <= s_axis.tdata;
            r_m_tkeep <= s_axis.tkeep;
            r_m_tuser <= s_axis.tuser;
            r_m_tlast <= s_axis.tlast;
        end else if (m_axis.tready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Commit sequence, packet and error counters; all wrap.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_hist_update <= 1'b0;
            r_hist_seq    <= '0;
            r_pkt_cnt     <= '0;
            r_hdr_err_cnt <= '0;
        end else begin
            r_hist_update <= w_commit;
            if (w_commit)             r_hist_seq    <= r_hist_seq + CNT_WIDTH'(1);
            if (w_m_hs && r_m_tlast)  r_pkt_cnt     <= r_pkt_cnt + CNT_WIDTH'(1);
            if (w_err_inc)            r_hdr_err_cnt <= r_hdr_err_cnt + CNT_WIDTH'(1);
        end
    end

    history_bank u_bank (
        .axis_aclk  (axis_aclk),
        .axis_reset (axis_reset),
        .i_wr_en    (w_hdr_hs && (r_state != HDR3)),
        .i_wr_beat  (r_state[1:0]),
        .i_tuples   (w_tuples),
        .i_ptr      (s_axis.tdata[PTR_MSB:PTR_LSB]),
        .i_commit   (w_commit),
        .i_rd_idx   (hist_rd_idx),
        .o_rd_tuple (hist_rd_tuple),
        .o_ptr      (hist_ptr)
    );

    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = r_m_valid;
    assign m_axis.tdata  = r_m_tdata;
    assign m_axis.tkeep  = r_m_tkeep;
    assign m_axis.tuser  = r_m_tuser;
    assign m_axis.tlast  = r_m_tlast;
    assign hist_update   = r_hist_update;
    assign hist_seq      = r_hist_seq;
    assign pkt_cnt       = r_pkt_cnt;
    assign hdr_err_cnt   = r_hdr_err_cnt;

endmodule
